accum_stage: RTL and testbench

ACCUM_STAGE -- requirements
Module: accum_stage

---
 rtl/accum_stage_if.sv | 27 ++
 rtl/accum_stage.sv | 113 +++++++++++
 tb/tb_accum_stage.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/accum_stage_if.sv
// Accumulator stage handshake bundle.
// Carries start/len command, input term stream and result stream.
interface accum_stage_if #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 8
);
  logic                 start;
  logic [CNT_WIDTH-1:0] len;
  logic                 in_valid;
  logic [WIDTH-1:0]     in_data;
  logic                 in_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic                 out_sat;
  logic                 out_ready;
  logic                 busy;

  modport master (
    output start, len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat, busy
  );

  modport slave (
    input  start, len, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat, busy
  );
endinterface

// File: rtl/accum_stage.sv
// Saturating accumulator stage: sums len signed terms
// in a wide accumulator and clamps the result to WIDTH bits.
module accum_stage #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 8,
  parameter int ACC_WIDTH = 40
) (
  input  logic          clk,
  input  logic          reset,
  accum_stage_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] ONE =
    {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  localparam logic signed [ACC_WIDTH-1:0] SMAX =
    {{(ACC_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SMIN =
    {{(ACC_WIDTH-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  localparam logic [WIDTH-1:0] OMAX =
    {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] OMIN =
    {1'b1, {(WIDTH-1){1'b0}}};

  state_t                       state;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic        [CNT_WIDTH-1:0]  remaining;

  logic signed [ACC_WIDTH-1:0]  acc_nxt;
  logic        [WIDTH-1:0]      sat_data;
  logic                         sat_flag;

  // Headroom of ACC_WIDTH-WIDTH bits keeps this add wrap-free
  always_comb begin
    acc_nxt = acc + {{(ACC_WIDTH-WIDTH){bus.in_data[WIDTH-1]}},
                     bus.in_data};
    sat_data = acc_nxt[WIDTH-1:0];
    sat_flag = 1'b0;
    if (acc_nxt > SMAX) begin
      sat_data = OMAX;
      sat_flag = 1'b1;
    end else if (acc_nxt < SMIN) begin
      sat_data = OMIN;
      sat_flag = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      acc           <= '0;
      remaining     <= '0;
      bus.out_data  <= '0;
      bus.out_sat   <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.in_ready  <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            acc       <= '0;
            remaining <= bus.len;
            bus.busy  <= 1'b1;
            if (bus.len != '0) begin
              state        <= ACCUM;
              bus.in_ready <= 1'b1;
            end else begin
              state         <= DONE;
              bus.out_valid <= 1'b1;
              bus.out_data  <= '0;
              bus.out_sat   <= 1'b0;
            end
          end
        end
        ACCUM: begin
          if (bus.in_valid) begin
            acc       <= acc_nxt;
            remaining <= remaining - ONE;
            if (remaining == ONE) begin
              state         <= DONE;
              bus.in_ready  <= 1'b0;
              bus.out_valid <= 1'b1;
              bus.out_data  <= sat_data;
              bus.out_sat   <= sat_flag;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          bus.in_ready  <= 1'b0;
          bus.out_valid <= 1'b0;
          bus.busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accum_stage.sv
// Self-checking bench for accum_stage.
// Directed and random transactions against a wide-integer sum model.
module tb_accum_stage;

  logic clk;
  logic reset;

  int n_chk;
  int n_fail;

  logic [31:0] terms[$];

  accum_stage_if #(.WIDTH(32), .CNT_WIDTH(8)) bus ();

  accum_stage #(
    .WIDTH(32),
    .CNT_WIDTH(8),
    .ACC_WIDTH(40)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".in_ready"},  64'(bus.in_ready),  64'd0);
    chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, ".busy"},      64'(bus.busy),      64'd0);
    chk({tag, ".out_data"},  64'(bus.out_data),  64'd0);
    chk({tag, ".out_sat"},   64'(bus.out_sat),   64'd0);
  endtask

  // Runs one transaction over the queued terms and checks the result.
  task automatic txn(input string tag, input int gmax, input int hold);
    longint sum;
    longint lo;
    longint hi;
    logic [31:0] exp_d;
    logic        exp_s;
    int n;
    int gap;
    n  = terms.size();
    lo = -(longint'(1) <<< 31);
    hi = (longint'(1) <<< 31) - 1;
    sum = 0;
    @(negedge clk);
    chk({tag, ".idle_busy"},  64'(bus.busy),      64'd0);
    chk({tag, ".idle_valid"}, 64'(bus.out_valid), 64'd0);
    bus.start = 1'b1;
    bus.len   = 8'(n);
    @(negedge clk);
    bus.start = 1'b0;
    bus.len   = 8'($urandom);
    for (int i = 0; i < n; i++) begin
      gap = (gmax > 0) ? int'($urandom_range(0, gmax)) : 0;
      for (int g = 0; g < gap; g++) begin
        chk({tag, ".gap_ready"}, 64'(bus.in_ready), 64'd1);
        @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = terms[i];
      if (i == 0 || i == n - 1)
        chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
      sum += longint'($signed(terms[i]));
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = $urandom;
    end
    if (sum > hi) begin
      exp_d = 32'h7FFF_FFFF; exp_s = 1'b1;
    end else if (sum < lo) begin
      exp_d = 32'h8000_0000; exp_s = 1'b1;
    end else begin
      exp_d = 32'(sum); exp_s = 1'b0;
    end
    chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, ".out_data"},  64'(bus.out_data),  64'(exp_d));
    chk({tag, ".out_sat"},   64'(bus.out_sat),   64'(exp_s));
    chk({tag, ".done_rdy"},  64'(bus.in_ready),  64'd0);
    chk({tag, ".done_busy"}, 64'(bus.busy),      64'd1);
    for (int h = 0; h < hold; h++) begin
      bus.start = 1'b1;
      bus.len   = 8'($urandom_range(1, 255));
      @(negedge clk);
      chk({tag, ".hold_valid"}, 64'(bus.out_valid), 64'd1);
      chk({tag, ".hold_data"},  64'(bus.out_data),  64'(exp_d));
    end
    bus.start     = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    chk({tag, ".ret_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, ".ret_busy"},  64'(bus.busy),      64'd0);
    chk({tag, ".ret_data"},  64'(bus.out_data),  64'(exp_d));
    chk({tag, ".ret_sat"},   64'(bus.out_sat),   64'(exp_s));
    @(negedge clk);
    chk({tag, ".no_restart"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset = 1'b1;

    terms = '{32'd5, -32'sd2, 32'd10};
    txn("basic", 0, 0);

    terms = '{32'h7FFF_FFFF, 32'h7FFF_FFFF};
    txn("satpos", 0, 1);

    terms = '{32'h8000_0000, 32'h8000_0000};
    txn("satneg", 0, 0);

    terms = {};
    txn("len0", 0, 0);

    terms = '{32'd100, -32'sd300, 32'd7, 32'd1000};
    txn("gaps", 3, 5);

    // Abort mid-transaction with an asynchronous reset
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = 8'd4;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'd9;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    #2 reset = 1'b0;
    #1 chk_zero("async_rst");
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst.valid", 64'(bus.out_valid), 64'd0);
    end

    terms = '{32'd7};
    txn("after_rst", 0, 0);

    terms = {};
    for (int i = 0; i < 255; i++) terms.push_back(32'h7FFF_FFFF);
    txn("len255", 0, 0);

    for (int r = 0; r < 6; r++) begin
      int n;
      n = int'($urandom_range(1, 20));
      terms = {};
      for (int i = 0; i < n; i++) begin
        if (r % 2 == 0)
          terms.push_back($urandom);
        else
          terms.push_back(32'($signed(8'($urandom))));
      end
      txn("rand", 2, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
